// File: rtl/vga_scanout_if.sv
// Scanout bus: frame buffer read port, buffer swap handshake and video outputs.
// The scanout engine is the master; the frame buffer / display side is the slave.
interface vga_scanout_if #(
    parameter int ADDR_WIDTH = 19
) ();
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  read_data;
    logic                  swap_request;
    logic                  swap;
    logic                  pixel;
    logic                  hsync;
    logic                  vsync;
    logic                  active;
    logic                  vblank;

    modport master (
        output read_addr, swap, pixel, hsync, vsync, active, vblank,
        input  read_data, swap_request
    );

    modport slave (
        input  read_addr, swap, pixel, hsync, vsync, active, vblank,
        output read_data, swap_request
    );
endinterface

// File: rtl/vga_scanout.sv
// VGA raster timing generator with row-major frame buffer address counter and
// vblank-synchronised double-buffer swap. All video outputs are registered.
module vga_scanout #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int HOR_FRONT_PORCH   = 16,
    parameter int HOR_SYNC          = 96,
    parameter int HOR_BACK_PORCH    = 48,
    parameter int VER_FRONT_PORCH   = 10,
    parameter int VER_SYNC          = 2,
    parameter int VER_BACK_PORCH    = 33
) (
    input  logic          clk,
    input  logic          rst_n,
    vga_scanout_if.master bus
);
    localparam int H_TOTAL      = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
    localparam int V_TOTAL      = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;
    localparam int FRAME_PIXELS = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
    localparam int ADDR_WIDTH   = $clog2(FRAME_PIXELS);
    localparam int H_WIDTH      = $clog2(H_TOTAL);
    localparam int V_WIDTH      = $clog2(V_TOTAL);
    localparam int HS_START     = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH;
    localparam int HS_END       = HS_START + HOR_SYNC;
    localparam int VS_START     = VER_ACTIVE_PIXELS + VER_FRONT_PORCH;
    localparam int VS_END       = VS_START + VER_SYNC;

    logic [H_WIDTH-1:0]    h_count, h_next;
    logic [V_WIDTH-1:0]    v_count, v_next;
    logic [ADDR_WIDTH-1:0] addr_count, addr_next;
    logic                  pending;
    logic                  visible, next_visible;
    logic                  swap_point, swap_fire;
    logic                  pixel_q, hsync_q, vsync_q, active_q, vblank_q, swap_q;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        h_next = h_count + 1'b1;
        v_next = v_count;
        if (int'(h_count) == H_TOTAL - 1) begin
            h_next = '0;
            v_next = (int'(v_count) == V_TOTAL - 1) ? '0 : v_count + 1'b1;
        end
    end

    assign visible      = (int'(h_count) < HOR_ACTIVE_PIXELS) && (int'(v_count) < VER_ACTIVE_PIXELS);
    assign next_visible = (int'(h_next) < HOR_ACTIVE_PIXELS) && (int'(v_next) < VER_ACTIVE_PIXELS);
    assign swap_point   = (h_count == '0) && (int'(v_count) == VER_ACTIVE_PIXELS);
    assign swap_fire    = swap_point && (pending || bus.swap_request);

    // The address steps only when moving onto a visible position, so it holds
    // through blanking and already points at x=0 when the next line starts.
    always_comb begin
        addr_next = addr_count;
        if ((h_next == '0) && (v_next == '0)) begin
            addr_next = '0;
        end else if (next_visible) begin
            addr_next = (int'(addr_count) == FRAME_PIXELS - 1) ? '0 : addr_count + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count    <= '0;
            v_count    <= '0;
            addr_count <= '0;
            pending    <= 1'b0;
            pixel_q    <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            active_q   <= 1'b0;
            vblank_q   <= 1'b0;
            swap_q     <= 1'b0;
        end else begin
            h_count    <= h_next;
            v_count    <= v_next;
            addr_count <= addr_next;
            pending    <= swap_fire ? 1'b0 : (pending | bus.swap_request);
            pixel_q    <= visible & bus.read_data;
            hsync_q    <= !((int'(h_count) >= HS_START) && (int'(h_count) < HS_END));
            vsync_q    <= !((int'(v_count) >= VS_START) && (int'(v_count) < VS_END));
            active_q   <= visible;
            vblank_q   <= int'(v_count) >= VER_ACTIVE_PIXELS;
            swap_q     <= swap_fire;
        end
    end

    assign bus.read_addr = addr_count;
    assign bus.pixel     = pixel_q;
    assign bus.hsync     = hsync_q;
    assign bus.vsync     = vsync_q;
    assign bus.active    = active_q;
    assign bus.vblank    = vblank_q;
    assign bus.swap      = swap_q;
endmodule
